seg_scan_capture: RTL and testbench
===================================

// Module: seg_scan_capture
// PURPOSE
//  Receive-side counterpart of the 4-digit multiplexed 7-seg scan bus (digit[3:0] + active-low anode[3:0]).
//  Samples the time-multiplexed bus, checks scan order, reassembles the 16-bit word.
//  Emits a one-cycle valid pulse per complete frame.
//  Used for loopback self-check of the display path and for capturing scan buses from companion boards.
// PARAMETERS
//  MIN_DWELL   1   consecutive cycles an anode code must be stable before its digit is accepted (>=1)
// PORTS
//  clk     in   1   system clock; all logic on posedge
//  reset   in   1   synchronous, active-high reset
//  digit   in   4   hex nibble currently driven on the scan bus
//  anode   in   4   active-low one-hot strobe; 0111=slot3, 1011=slot2, 1101=slot1, 1110=slot0, 1111=blank
//  data    out  16  last complete frame: slot3->[15:12], slot2->[11:8], slot1->[7:4], slot0->[3:0]
//  valid   out  1   one-cycle pulse; data updated on the same edge
//  err     out  1   one-cycle pulse on illegal anode code or out-of-order slot
// BEHAVIOUR
//  Reset (clk edge with reset=1): data=0, valid=0, err=0, state=SYNC, dwell count=0, partial frame=0.
//   Reset mid-frame discards the partial frame; data keeps reset value 0 until the next complete frame.
//  Dwell: counter tracks consecutive cycles of an identical anode code; it restarts at 1 whenever the code changes.
//   A code is "accepted" on the cycle the count reaches MIN_DWELL, exactly once per run.
//   Further cycles of the same code are ignored; no re-acceptance.
//   Counter saturates; width $clog2(MIN_DWELL+1).
//  Blank (1111): never accepted; resets dwell; does not break sequence (gaps between slots allowed).
//  Illegal code (any value other than the four slot codes or blank): err=1 next cycle; state->SYNC; partial discarded.
//  FSM, evaluated on acceptance only:
//   SYNC: slot3 accepted -> latch digit into part[15:12], go EXP2; any other slot ignored (no err).
//   EXP2: slot2 -> part[11:8], EXP1.
//   EXP1: slot1 -> part[7:4], EXP0.
//   EXP0: slot0 -> data<={part[15:4],digit}, valid=1, go EXP3.
//   EXP3: slot3 -> part[15:12], EXP2 (continuous framing).
//   In any EXPk, accepted slot != k: err=1.
//    If the offending slot is slot3, treat it as a new frame start: latch it, go EXP2.
//    Otherwise go SYNC.
//  Latency: with MIN_DWELL=1, valid/data appear on the edge after the edge sampling anode=1110 of a legal frame.
//   Each additional dwell cycle adds 1 cycle.
//  Simultaneous: err and valid are never both 1 in the same cycle. reset has priority over all events.
//  Bus driven at one slot per clk (DWELL=1, order 3,2,1,0): valid every 4 cycles after the first frame.
// CONFIGURATION
//  SEG_CAPTURE_CHANGE_EN defined:
//   valid pulses only when the completed frame differs from current data.
//   The first frame after reset always pulses, via a first-frame flag.
//   data is still written every frame.
//  SEG_CAPTURE_CHANGE_EN undefined: valid pulses on every completed frame.
// STRUCTURE
//  Package seg_scan_pkg:
//   anode code localparams (AN_SLOT3..AN_SLOT0, AN_BLANK).
//   FSM state encoding (SYNC, EXP3, EXP2, EXP1, EXP0; 3-bit).
//   Slot index type (2-bit).
//  Sub-module seg_anode_decode, combinational:
//   anode -> {slot[1:0], is_slot, is_blank, is_illegal}.
//   Shared with the display driver's self-check.
//  Top: dwell counter, FSM, partial-frame register, output registers.
// TESTING
//  1. reset=1 for 2 cycles -> data=0000, valid=0, err=0; then scan 0x1234 (0111/1,1011/2,1101/3,1110/4) -> valid 1 cycle after 1110 cycle, data=0x1234.
//  2. Continuous scan of 0xBEEF, 3 frames -> valid every 4 cycles, data=0xBEEF, err never 1.
//  3. Slot order 0111,1101 -> err pulse; then 1011,1101,1110 ignored until 0111 -> no valid until next full frame.
//  4. anode=0011 mid-frame -> err 1 cycle, state SYNC, data unchanged; next legal frame 0xA5C3 -> data=0xA5C3.
//  5. MIN_DWELL=3, each slot held 3 cycles with 1111 gaps, frame 0x0F0F -> valid once per frame.
//     Same with slots held only 2 cycles -> no valid.
//  6. reset asserted during EXP1, then frame 0x9999 -> data=0x9999.
//     With SEG_CAPTURE_CHANGE_EN, a repeat 0x9999 frame gives no valid pulse.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 7-segment scan-bus capture path: anode codes,
// capture FSM states and slot index helpers.
package seg_scan_pkg;

  localparam logic [3:0] AN_SLOT3 = 4'b0111;
  localparam logic [3:0] AN_SLOT2 = 4'b1011;
  localparam logic [3:0] AN_SLOT1 = 4'b1101;
  localparam logic [3:0] AN_SLOT0 = 4'b1110;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  typedef enum logic [2:0] {
    SYNC = 3'd0,
    EXP3 = 3'd1,
    EXP2 = 3'd2,
    EXP1 = 3'd3,
    EXP0 = 3'd4
  } state_t;

  typedef logic [1:0] slot_t;

  // Slot the FSM is waiting for in a given EXPk state.
  function automatic slot_t expected_slot(input state_t s);
    case (s)
      EXP3:    return 2'd3;
      EXP2:    return 2'd2;
      EXP1:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // State reached after a slot is accepted in order (or as a new frame start).
  function automatic state_t state_after(input slot_t s);
    case (s)
      2'd3:    return EXP2;
      2'd2:    return EXP1;
      2'd1:    return EXP0;
      default: return EXP3;
    endcase
  endfunction

endpackage

// File: rtl/seg_anode_decode.sv
// Combinational classifier for the active-low one-hot anode strobe:
// slot index plus slot / blank / illegal flags.
module seg_anode_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] anode,
  output slot_t      slot,
  output logic       is_slot,
  output logic       is_blank,
  output logic       is_illegal
);

  always_comb begin
    slot       = 2'd0;
    is_slot    = 1'b0;
    is_blank   = 1'b0;
    is_illegal = 1'b0;
    case (anode)
      AN_SLOT3: begin slot = 2'd3; is_slot = 1'b1; end
      AN_SLOT2: begin slot = 2'd2; is_slot = 1'b1; end
      AN_SLOT1: begin slot = 2'd1; is_slot = 1'b1; end
      AN_SLOT0: begin slot = 2'd0; is_slot = 1'b1; end
      AN_BLANK: is_blank = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of the 4-digit multiplexed 7-seg scan bus: samples the bus,
// checks slot order and reassembles the 16-bit word.
// Optional macro SEG_CAPTURE_CHANGE_EN: pulse valid only when the frame changes.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int MIN_DWELL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  digit,
  input  logic [3:0]  anode,
  output logic [15:0] data,
  output logic        valid,
  output logic        err
);

  localparam int CW = $clog2(MIN_DWELL + 1);
  localparam logic [CW-1:0] DWELL_MAX = CW'(MIN_DWELL);

  logic [3:0]    anode_reg, digit_reg, prev_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  state_t        state_reg, state_next;
  logic [15:4]   part_reg, part_next;
  logic [15:0]   data_reg;
  logic          valid_reg, err_reg;
  logic          valid_next, err_next, frame_done, accept, restart;
  logic [15:0]   frame_word;

  slot_t slot;
  logic  is_slot, is_blank, is_illegal;

  seg_anode_decode u_decode (
    .anode      (anode_reg),
    .slot       (slot),
    .is_slot    (is_slot),
    .is_blank   (is_blank),
    .is_illegal (is_illegal)
  );

  // A slot code is accepted exactly once, on the cycle its run reaches MIN_DWELL.
  always_comb begin
    restart  = (anode_reg != prev_reg) || (cnt_reg == '0);
    cnt_next = cnt_reg;
    if (is_blank || is_illegal)
      cnt_next = '0;
    else if (restart)
      cnt_next = CW'(1);
    else if (cnt_reg != DWELL_MAX)
      cnt_next = cnt_reg + CW'(1);
    accept = is_slot && (cnt_next == DWELL_MAX) && (restart || cnt_reg != DWELL_MAX);
  end

  always_comb begin
    state_next = state_reg;
    part_next  = part_reg;
    frame_done = 1'b0;
    err_next   = 1'b0;
    if (is_illegal) begin
      err_next   = 1'b1;
      state_next = SYNC;
      part_next  = '0;
    end else if (accept) begin
      if (state_reg == SYNC) begin
        if (slot == 2'd3) begin
          part_next  = {digit_reg, 8'h00};
          state_next = EXP2;
        end
      end else if (slot == expected_slot(state_reg)) begin
        state_next = state_after(slot);
        case (slot)
          2'd3:    part_next[15:12] = digit_reg;
          2'd2:    part_next[11:8]  = digit_reg;
          2'd1:    part_next[7:4]   = digit_reg;
          default: frame_done       = 1'b1;
        endcase
      end else begin
        // Out-of-order slot3 restarts framing instead of dropping to SYNC.
        err_next = 1'b1;
        if (slot == 2'd3) begin
          part_next  = {digit_reg, 8'h00};
          state_next = EXP2;
        end else begin
          part_next  = '0;
          state_next = SYNC;
        end
      end
    end
  end

  assign frame_word = {part_reg, digit_reg};

`ifdef SEG_CAPTURE_CHANGE_EN
  logic first_reg;
  assign valid_next = frame_done && (first_reg || (frame_word != data_reg));
`else
  assign valid_next = frame_done;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      anode_reg <= AN_BLANK;
      digit_reg <= '0;
      prev_reg  <= AN_BLANK;
      cnt_reg   <= '0;
      state_reg <= SYNC;
      part_reg  <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
`ifdef SEG_CAPTURE_CHANGE_EN
      first_reg <= 1'b1;
`endif
    end else begin
      anode_reg <= anode;
      digit_reg <= digit;
      prev_reg  <= anode_reg;
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
      part_reg  <= part_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      if (frame_done)
        data_reg <= frame_word;
`ifdef SEG_CAPTURE_CHANGE_EN
      if (frame_done)
        first_reg <= 1'b0;
`endif
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: two instances (dwell 1 and 3) share one
// scan bus; a frame-level reference model predicts valid/err events and their cycle.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  digit = 4'h0;
  logic [3:0]  anode = 4'hF;
  logic [15:0] data1, data3;
  logic        valid1, valid3, err1, err3;

  seg_scan_capture #(.MIN_DWELL(1)) dut1 (
    .clk(clk), .reset(reset), .digit(digit), .anode(anode),
    .data(data1), .valid(valid1), .err(err1)
  );

  seg_scan_capture #(.MIN_DWELL(3)) dut3 (
    .clk(clk), .reset(reset), .digit(digit), .anode(anode),
    .data(data3), .valid(valid3), .err(err3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SEG_CAPTURE_CHANGE_EN
  localparam bit CHANGE = 1'b1;
`else
  localparam bit CHANGE = 1'b0;
`endif

  typedef struct {
    bit          is_err;
    int          cyc;
    logic [15:0] data;
  } ev_t;

  ev_t q1[$];
  ev_t q3[$];
  int  n_checks = 0;
  int  n_fail = 0;

  // Reference model state, one entry per instance.
  int          dwell[2] = '{1, 3};
  logic [3:0]  m_last[2];
  int          m_run[2];
  int          m_exp[2];    // next expected slot, -1 while hunting for slot3
  logic [3:0]  m_part[2][4];
  logic [15:0] m_data[2];
  bit          m_first[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int slot_of(input logic [3:0] an);
    case (an)
      4'b0111: return 3;
      4'b1011: return 2;
      4'b1101: return 1;
      4'b1110: return 0;
      4'b1111: return -1;
      default: return -2;
    endcase
  endfunction

  function automatic logic [3:0] slot_code(input int s);
    case (s)
      3:       return 4'b0111;
      2:       return 4'b1011;
      1:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic push(input int k, input bit is_err, input logic [15:0] d);
    ev_t ev;
    ev.is_err = is_err;
    ev.cyc    = cyc + 2;   // one cycle to sample the bus, one to register outputs
    ev.data   = d;
    if (k == 0) q1.push_back(ev);
    else        q3.push_back(ev);
  endtask

  task automatic model_reset(input int k);
    m_last[k]  = 4'hF;
    m_run[k]   = 0;
    m_exp[k]   = -1;
    m_data[k]  = 16'h0000;
    m_first[k] = 1'b1;
    for (int i = 0; i < 4; i++) m_part[k][i] = 4'h0;
  endtask

  task automatic model_accept(input int k, input int s, input logic [3:0] dg);
    logic [15:0] w;
    if (m_exp[k] == -1) begin
      if (s == 3) begin m_part[k][3] = dg; m_exp[k] = 2; end
    end else if (s == m_exp[k]) begin
      m_part[k][s] = dg;
      if (s == 0) begin
        w = {m_part[k][3], m_part[k][2], m_part[k][1], m_part[k][0]};
        if (!CHANGE || m_first[k] || w != m_data[k]) push(k, 1'b0, w);
        m_data[k]  = w;
        m_first[k] = 1'b0;
        m_exp[k]   = 3;
      end else begin
        m_exp[k] = s - 1;
      end
    end else begin
      push(k, 1'b1, m_data[k]);
      if (s == 3) begin m_part[k][3] = dg; m_exp[k] = 2; end
      else m_exp[k] = -1;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] an, input logic [3:0] dg);
    int s;
    s = slot_of(an);
    if (s == -1) begin
      m_run[k] = 0;
    end else if (s == -2) begin
      m_run[k] = 0;
      m_exp[k] = -1;
      push(k, 1'b1, m_data[k]);
    end else begin
      m_run[k] = (an == m_last[k]) ? m_run[k] + 1 : 1;
      if (m_run[k] == dwell[k]) model_accept(k, s, dg);
    end
    m_last[k] = an;
  endtask

  task automatic drive(input logic [3:0] an, input logic [3:0] dg);
    anode = an;
    digit = dg;
    model_step(0, an, dg);
    model_step(1, an, dg);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'hF, 4'h0);
  endtask

  task automatic send_frame(input logic [15:0] w, input int hold, input int gap);
    for (int s = 3; s >= 0; s--) begin
      repeat (hold) drive(slot_code(s), w[4*s +: 4]);
      repeat (gap) drive(4'hF, 4'h0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    anode = 4'hF;
    digit = 4'h0;
    model_reset(0);
    model_reset(1);
    q1.delete();
    q3.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_data1", data1, 16'h0000);
    check("reset_valid1", valid1, 1'b0);
    check("reset_err1", err1, 1'b0);
    check("reset_data3", data3, 16'h0000);
    check("reset_valid3", valid3, 1'b0);
    check("reset_err3", err3, 1'b0);
  endtask

  // Monitor: missed, unexpected and mismatched events for both instances.
  function automatic int qsize(input int k);
    return (k == 0) ? q1.size() : q3.size();
  endfunction

  function automatic ev_t qfront(input int k);
    return (k == 0) ? q1[0] : q3[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(q1.pop_front());
    else        void'(q3.pop_front());
  endtask

  task automatic monitor(input int k, input logic v, input logic e, input logic [15:0] d);
    ev_t ev;
    while (qsize(k) > 0 && qfront(k).cyc < cyc) begin
      ev = qfront(k);
      qpop(k);
      n_checks++;
      n_fail++;
      $display("FAIL missed_event dut%0d: got no pulse, expected %s data=%h at cycle %0d",
               k, ev.is_err ? "err" : "valid", ev.data, ev.cyc);
    end
    if (v === 1'b1 && e === 1'b1) check($sformatf("valid_err_overlap dut%0d", k), 1'b1, 1'b0);
    if (v === 1'b1 || e === 1'b1) begin
      if (qsize(k) > 0 && qfront(k).cyc == cyc) begin
        ev = qfront(k);
        qpop(k);
        check($sformatf("event_kind_err dut%0d", k), e, ev.is_err);
        check($sformatf("event_data dut%0d", k), d, ev.data);
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event dut%0d: got valid=%b err=%b data=%h, expected no pulse (cycle %0d)",
                 k, v, e, d, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0, valid1, err1, data1);
    monitor(1, valid3, err3, data3);
  end

  logic [15:0] last_word;

  initial begin
    model_reset(0);
    model_reset(1);
    do_reset();

    // Single frame, then continuous framing.
    send_frame(16'h1234, 1, 0);
    idle(4);
    repeat (3) send_frame(16'hBEEF, 1, 0);
    idle(4);

    // Out-of-order slot, stray slots ignored until the next slot3.
    drive(4'b0111, 4'h1);
    drive(4'b1101, 4'h3);
    drive(4'b1011, 4'h2);
    drive(4'b1101, 4'h3);
    drive(4'b1110, 4'h4);
    send_frame(16'h5678, 1, 0);
    idle(4);

    // Illegal anode code mid-frame.
    drive(4'b0111, 4'hA);
    drive(4'b1011, 4'h5);
    drive(4'b0011, 4'h0);
    send_frame(16'hA5C3, 1, 0);
    idle(4);

    // Dwell boundary: 3-cycle holds accepted by both, 2-cycle holds only by dwell 1.
    repeat (2) send_frame(16'h0F0F, 3, 1);
    send_frame(16'h0F0F, 2, 1);
    send_frame(16'h1E1E, 2, 1);
    idle(4);

    // Reset during EXP1, then a fresh frame and a repeat of it.
    drive(4'b0111, 4'h7);
    drive(4'b1011, 4'h7);
    drive(4'hF, 4'h0);
    do_reset();
    send_frame(16'h9999, 1, 0);
    idle(3);
    send_frame(16'h9999, 1, 0);
    idle(4);

    // Randomized frames with variable hold, gaps, illegal and misordered codes.
    last_word = 16'h0000;
    for (int f = 0; f < 300; f++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w = last_word;
      last_word = w;
      for (int s = 3; s >= 0; s--) begin
        logic [3:0] code;
        int r;
        r = $urandom_range(0, 99);
        code = slot_code(s);
        if (r < 3) begin
          do code = 4'($urandom_range(0, 15)); while (slot_of(code) != -2);
        end else if (r < 7) begin
          code = slot_code($urandom_range(0, 3));
        end
        repeat ($urandom_range(1, 4)) drive(code, w[4*s +: 4]);
        repeat ($urandom_range(0, 1)) drive(4'hF, 4'h0);
      end
    end

    idle(6);
    check("queue_drained dut0", q1.size(), 0);
    check("queue_drained dut1", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
